// File: rtl/rns_maxpool_ctrl.sv
// -----------------------------------------------------------------------------
// rns_maxpool_ctrl
//   Sequential max-pooling controller for RNS-encoded activations in the
//   moduli set {2^N, 2^N+1, 2^N-1}. Beats arrive on a valid/ready stream. Each
//   window is folded into a running maximum with one shared comparator
//   (comp). One maximum triplet per window leaves on a valid/ready output.
//
//   Optional feature macro: RNS_MAXPOOL_IDX_EN
//     When defined, it adds out_idx, the 0-based position of the maximum
//     within the window. On ties the earliest position is reported.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   input handshake; in_ready = (state != OUT)
//   in_r1 / in_r2 / in_r3 residues mod 2^N, 2^N+1, 2^N-1
//   in_last               closes the current window on this beat
//   out_valid / out_ready output handshake
//   out_r1 / out_r2 / out_r3  window maximum residues
//   busy                  a window is partially accumulated
//   out_idx [CW-1:0]      (RNS_MAXPOOL_IDX_EN only) beat index of the maximum
// -----------------------------------------------------------------------------

// Combinational RNS magnitude comparator: o_gt = X(b) > X(a), where X is the
// CRT-decoded integer in [0, 2^N(2^N+1)(2^N-1)).
module comp #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a1,
  input  logic [N:0]   i_a2,
  input  logic [N-1:0] i_a3,
  input  logic [N-1:0] i_b1,
  input  logic [N:0]   i_b2,
  input  logic [N-1:0] i_b3,
  output logic         o_gt
);
  localparam int XW = 3*N + 2;
  localparam logic [XW-1:0] M1   = XW'(2**N);
  localparam logic [XW-1:0] M2   = XW'(2**N + 1);
  localparam logic [XW-1:0] M3   = XW'(2**N - 1);
  localparam logic [XW-1:0] HALF = XW'(2**(N-1));

  // Mixed-radix decode: X = r1 + 2^N*(a + (2^N+1)*b).
  //   2^N == -1 mod (2^N+1)  ->  a = (r1 - r2) mod (2^N+1)
  //   2^N ==  1 mod (2^N-1)  ->  y == (r3 - r1) mod (2^N-1)
  //   (2^N+1) == 2 mod (2^N-1), and 2^(N-1) is the inverse of 2
  //     ->  b = ((y - a) * 2^(N-1)) mod (2^N-1)
  function automatic logic [XW-1:0] decode(input logic [N-1:0] r1,
                                           input logic [N:0]   r2,
                                           input logic [N-1:0] r3);
    logic [XW-1:0] x1, x2, x3, a, c, b;
    x1 = XW'(r1);
    x2 = XW'(r2) % M2;
    x3 = XW'(r3) % M3;
    a  = (x1 + M2 - x2) % M2;
    c  = (x3 + M3 - (x1 % M3)) % M3;
    b  = (((c + M3 - (a % M3)) % M3) * HALF) % M3;
    return x1 + M1 * (a + M2 * b);
  endfunction

  logic [XW-1:0] w_xa, w_xb;

  always_comb begin
    w_xa = decode(i_a1, i_a2, i_a3);
    w_xb = decode(i_b1, i_b2, i_b3);
    o_gt = (w_xb > w_xa);
  end
endmodule

module rns_maxpool_ctrl #(
  parameter int N   = 5,
  parameter int WIN = 4,
  parameter int CW  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r1,
  input  logic [N:0]   in_r2,
  input  logic [N-1:0] in_r3,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r1,
  output logic [N:0]   out_r2,
  output logic [N-1:0] out_r3,
  output logic         busy
`ifdef RNS_MAXPOOL_IDX_EN
  , output logic [CW-1:0] out_idx
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc1, r_acc3, r_out1, r_out3;
  logic [N:0]    r_acc2, r_out2;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;

  logic          w_in_gt;
  logic [N-1:0]  w_max1, w_max3;
  logic [N:0]    w_max2;
  logic [CW:0]   w_cnt_inc;
  logic          w_close;

`ifdef RNS_MAXPOOL_IDX_EN
  logic [CW-1:0] r_idx, r_out_idx;
  logic [CW-1:0] w_idx_nxt;
`endif

  // acc is operand 1 and the input is operand 2. A tie keeps acc.
  comp #(.N(N)) u_comp (
    .i_a1 (r_acc1), .i_a2 (r_acc2), .i_a3 (r_acc3),
    .i_b1 (in_r1),  .i_b2 (in_r2),  .i_b3 (in_r3),
    .o_gt (w_in_gt)
  );

  always_comb begin
    w_max1    = w_in_gt ? in_r1 : r_acc1;
    w_max2    = w_in_gt ? in_r2 : r_acc2;
    w_max3    = w_in_gt ? in_r3 : r_acc3;
    w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);
    w_close   = in_last || (w_cnt_inc == (CW+1)'(WIN));
`ifdef RNS_MAXPOOL_IDX_EN
    // In ACC, r_cnt is the 0-based position of the beat being presented.
    w_idx_nxt = w_in_gt ? r_cnt : r_idx;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc1      <= '0;
      r_acc2      <= '0;
      r_acc3      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out3      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
`ifdef RNS_MAXPOOL_IDX_EN
      r_idx       <= '0;
      r_out_idx   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc1 <= in_r1;
            r_acc2 <= in_r2;
            r_acc3 <= in_r3;
            r_cnt  <= CW'(1);
`ifdef RNS_MAXPOOL_IDX_EN
            r_idx  <= '0;
`endif
            if (in_last || (WIN == 1)) begin
              r_out1      <= in_r1;
              r_out2      <= in_r2;
              r_out3      <= in_r3;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
`ifdef RNS_MAXPOOL_IDX_EN
              r_out_idx   <= '0;
`endif
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            r_acc1 <= w_max1;
            r_acc2 <= w_max2;
            r_acc3 <= w_max3;
`ifdef RNS_MAXPOOL_IDX_EN
            r_idx  <= w_idx_nxt;
`endif
            if (w_close) begin
              r_out1      <= w_max1;
              r_out2      <= w_max2;
              r_out3      <= w_max3;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
`ifdef RNS_MAXPOOL_IDX_EN
              r_out_idx   <= w_idx_nxt;
`endif
            end else begin
              r_cnt <= w_cnt_inc[CW-1:0];
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state != OUT);
  assign busy      = (r_state == ACC);
  assign out_valid = r_out_valid;
  assign out_r1    = r_out1;
  assign out_r2    = r_out2;
  assign out_r3    = r_out3;
`ifdef RNS_MAXPOOL_IDX_EN
  assign out_idx   = r_out_idx;
`endif

endmodule

// File: tb/tb_rns_maxpool_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rns_maxpool_ctrl
//   Self-checking bench for rns_maxpool_ctrl (N=5, WIN=4, CW=4). Stimulus is
//   drawn as plain integers X in [0, M). The residues are X mod each modulus.
//   The reference keeps the accepted beats of the open window in a queue. It
//   closes the window on in_last or after WIN beats and takes the integer
//   maximum. On ties the earliest beat is kept.
// -----------------------------------------------------------------------------
module tb_rns_maxpool_ctrl;
  localparam int N   = 5;
  localparam int WIN = 4;
  localparam int CW  = 4;
  localparam int M1  = 2**N;
  localparam int M2  = 2**N + 1;
  localparam int M3  = 2**N - 1;
  localparam int MT  = M1 * M2 * M3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [N-1:0] in_r1, in_r3, out_r1, out_r3;
  logic [N:0]   in_r2, out_r2;
`ifdef RNS_MAXPOOL_IDX_EN
  logic [CW-1:0] out_idx;
`endif

  rns_maxpool_ctrl #(.N(N), .WIN(WIN), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r1     (in_r1),
    .in_r2     (in_r2),
    .in_r3     (in_r3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r1    (out_r1),
    .out_r2    (out_r2),
    .out_r3    (out_r3),
    .busy      (busy)
`ifdef RNS_MAXPOOL_IDX_EN
    , .out_idx (out_idx)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q_win[$];
  bit m_pend = 0;
  int m_max  = 0;
  int m_idx  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the registered state, advance the model.
  task automatic step(input bit v, input int x, input bit last, input bit ordy);
    bit in_fire, out_fire;
    in_valid  = v;
    in_r1     = N'(x % M1);
    in_r2     = (N+1)'(x % M2);
    in_r3     = N'(x % M3);
    in_last   = last;
    out_ready = ordy;
    check("in_ready",  32'(in_ready),  32'(!m_pend));
    check("out_valid", 32'(out_valid), 32'(m_pend));
    check("busy",      32'(busy),      32'(q_win.size() != 0));
    if (m_pend) begin
      check("out_r1", 32'(out_r1), 32'(m_max % M1));
      check("out_r2", 32'(out_r2), 32'(m_max % M2));
      check("out_r3", 32'(out_r3), 32'(m_max % M3));
`ifdef RNS_MAXPOOL_IDX_EN
      check("out_idx", 32'(out_idx), 32'(m_idx));
`endif
    end
    in_fire  = v && !m_pend;
    out_fire = m_pend && ordy;
    if (out_fire) m_pend = 0;
    if (in_fire) begin
      q_win.push_back(x);
      if (last || q_win.size() == WIN) begin
        m_max = q_win[0];
        m_idx = 0;
        for (int i = 1; i < q_win.size(); i++)
          if (q_win[i] > m_max) begin
            m_max = q_win[i];
            m_idx = i;
          end
        m_pend = 1;
        q_win.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    step(1, a, 0, 1);
    step(1, b, 0, 1);
    step(1, c, 0, 1);
    step(1, d, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_r1 = '0; in_r2 = '0; in_r3 = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_r1",    32'(out_r1),    32'd0);
    check("rst_out_r2",    32'(out_r2),    32'd0);
    check("rst_out_r3",    32'(out_r3),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic window: maximum is 100 = (4,1,7) at position 1.
    window4(5, 100, 37, 2);
    // Ties: the first 37 wins.
    window4(37, 37, 2, 2);
    // Early close after two beats, then a clean full window.
    step(1, 2, 0, 1);
    step(1, 100, 1, 1);
    step(0, 0, 0, 1);
    window4(1, 2, 3, 4);
    // in_last on the first beat, and in_last together with the 4th beat.
    step(1, 77, 1, 1);
    step(0, 0, 0, 1);
    step(1, 9, 0, 1);
    step(1, 8, 0, 1);
    step(1, 7, 0, 1);
    step(1, 6, 1, 1);
    step(0, 0, 0, 1);
    // Top of the range wins.
    window4(MT - 1, 0, 1, 2);

    // Backpressure: hold OUT for 5 cycles with input pending.
    step(1, 5, 0, 1);
    step(1, 100, 0, 1);
    step(1, 37, 0, 1);
    step(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 300, 0, 0);
    step(1, 300, 0, 1);
    step(1, 300, 0, 1);
    step(1, 301, 0, 1);
    step(1, 302, 0, 1);
    step(1, 303, 0, 1);
    step(0, 0, 0, 1);

    // Reset mid-window: outputs return to zero at once.
    step(1, 5, 0, 1);
    step(1, 37, 0, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_r1",    32'(out_r1),    32'd0);
    check("midrst_out_r2",    32'(out_r2),    32'd0);
    check("midrst_out_r3",    32'(out_r3),    32'd0);
    q_win.delete();
    m_pend = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    window4(2, 5, 37, 100);

    // Reset while in OUT.
    step(1, 10, 1, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("outrst_out_valid", 32'(out_valid), 32'd0);
    check("outrst_out_r1",    32'(out_r1),    32'd0);
    q_win.delete();
    m_pend = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic, biased towards small values so that ties occur.
    for (int i = 0; i < 1500; i++) begin
      int x;
      case ($urandom_range(0, 5))
        0:       x = int'($urandom_range(0, 3));
        1:       x = MT - 1 - int'($urandom_range(0, 1));
        default: x = int'($urandom_range(0, MT - 1));
      endcase
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
